// File: rtl/pc_pkg.sv
// Shared defaults and next-PC source encoding for the fetch PC generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

    localparam int unsigned PC_WIDTH      = 32;
    localparam logic [31:0] PC_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR = 32'h0000_0080;
    localparam int unsigned PC_INST_BYTES = 4;
    localparam int unsigned PC_RAS_DEPTH  = 4;

    // Next-PC sources, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_REDIR,
        SEL_RAS,
        SEL_JUMP,
        SEL_HOLD,
        SEL_SEQ
    } next_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the pipeline control logic (master) and pc_gen (slave).
// Latency: wires only.
// Backpressure: stall holds the PC; redirect/exception requests bypass it.
// Signals: stall, exc_req, redirect_valid/redirect_pc, jump_valid/jump_target,
//          ras_push/ras_push_addr, ras_pop in; pc_o, pc_plus_o, ras_top_o, ras_count_o, ras_empty_o out.
interface pc_gen_if
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH,
    parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic             exc_req;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             jump_valid;
    logic [WIDTH-1:0] jump_target;
    logic             ras_push;
    logic [WIDTH-1:0] ras_push_addr;
    logic             ras_pop;
    logic [WIDTH-1:0] pc_o;
    logic [WIDTH-1:0] pc_plus_o;
    logic [WIDTH-1:0] ras_top_o;
    logic [CW-1:0]    ras_count_o;
    logic             ras_empty_o;

    modport master (
        output stall, exc_req, redirect_valid, redirect_pc, jump_valid, jump_target,
               ras_push, ras_push_addr, ras_pop,
        input  pc_o, pc_plus_o, ras_top_o, ras_count_o, ras_empty_o
    );

    modport slave (
        input  stall, exc_req, redirect_valid, redirect_pc, jump_valid, jump_target,
               ras_push, ras_push_addr, ras_pop,
        output pc_o, pc_plus_o, ras_top_o, ras_count_o, ras_empty_o
    );

endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: push/pop/clear, oldest entry overwritten when full.
// Latency: updates on the clock edge; top_o/count_o/empty_o are direct from state.
// Backpressure: none; the caller gates push/pop (stall, redirect, exception).
// Ports: clk, reset (async active-low), clear, push, pop, push_addr in; top_o, count_o, empty_o out.
module ras_stack #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_addr,
    output logic [WIDTH-1:0]           top_o,
    output logic [$clog2(RAS_DEPTH):0] count_o,
    output logic                       empty_o
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    top_q;
    logic [PW-1:0]    top_inc;
    logic [CW-1:0]    count_q;
    logic             empty;

    assign empty   = (count_q == '0);
    // Depth is a power of two, so the pointer wraps naturally.
    assign top_inc = top_q + PW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem[i] <= '0;
            end
            top_q   <= '0;
            count_q <= '0;
        end else if (clear) begin
            top_q   <= '0;
            count_q <= '0;
        end else if (push && pop && !empty) begin
            // Return then call: replace the top in place.
            mem[top_q] <= push_addr;
        end else if (push) begin
            // Also covers push+pop on an empty stack.
            mem[top_inc] <= push_addr;
            top_q        <= top_inc;
            if (count_q != FULL) begin
                count_q <= count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            top_q   <= top_q - PW'(1);
            count_q <= count_q - CW'(1);
        end
    end

    // Stale data stays in the array after pops; hide it when empty.
    assign top_o   = empty ? '0 : mem[top_q];
    assign count_o = count_q;
    assign empty_o = empty;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with priority next-PC select (exception, redirect, RAS return, jump, hold, sequential).
// Latency: selected PC appears on pc_o one cycle after sampling; pc_plus_o/ras_top_o combinational from state.
// Backpressure: stall holds the PC and blocks RAS updates; exception and redirect override stall.
// Ports: clk, reset (async active-low), bus (pc_gen_if.slave).
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH      = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_EXC_VECTOR),
    parameter int unsigned      INST_BYTES = PC_INST_BYTES,
    parameter int unsigned      RAS_DEPTH  = PC_RAS_DEPTH
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] ras_top;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_upd_ok;
    logic             ras_push_en;
    logic             ras_pop_en;
    logic             pop_hit;
    next_sel_e        sel;

    assign pc_plus = pc_q + WIDTH'(INST_BYTES);

    // The stack only moves on a clean, unstalled fetch slot; exception clears it separately.
    assign ras_upd_ok  = !bus.stall && !bus.exc_req && !bus.redirect_valid;
    assign ras_push_en = bus.ras_push && ras_upd_ok;
    assign ras_pop_en  = bus.ras_pop && ras_upd_ok;

    // A pop on an empty stack is not a prediction; it falls through to jump/sequential.
    assign pop_hit = bus.ras_pop && !ras_empty && !bus.stall;

    always_comb begin
        sel = SEL_SEQ;
        if (bus.exc_req) begin
            sel = SEL_EXC;
        end else if (bus.redirect_valid) begin
            sel = SEL_REDIR;
        end else if (pop_hit) begin
            sel = SEL_RAS;
        end else if (bus.jump_valid && !bus.stall) begin
            sel = SEL_JUMP;
        end else if (bus.stall) begin
            sel = SEL_HOLD;
        end
    end

    always_comb begin
        pc_d = pc_plus;
        unique case (sel)
            SEL_EXC:   pc_d = EXC_VECTOR;
            SEL_REDIR: pc_d = bus.redirect_pc;
            SEL_RAS:   pc_d = ras_top;
            SEL_JUMP:  pc_d = bus.jump_target;
            SEL_HOLD:  pc_d = pc_q;
            SEL_SEQ:   pc_d = pc_plus;
            default:   pc_d = pc_plus;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.exc_req),
        .push      (ras_push_en),
        .pop       (ras_pop_en),
        .push_addr (bus.ras_push_addr),
        .top_o     (ras_top),
        .count_o   (ras_count),
        .empty_o   (ras_empty)
    );

    assign bus.pc_o        = pc_q;
    assign bus.pc_plus_o   = pc_plus;
    assign bus.ras_top_o   = ras_top;
    assign bus.ras_count_o = ras_count;
    assign bus.ras_empty_o = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a queue-based model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall, redirect and exception are exercised directly and at random.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    // Reference model: PC value and the stack as a list, newest entry last.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];

    pc_gen_if #(.WIDTH(32), .RAS_DEPTH(DEPTH)) bus ();

    pc_gen #(
        .WIDTH      (32),
        .RESET_PC   (32'h0),
        .EXC_VECTOR (32'h80),
        .INST_BYTES (4),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model from the inputs currently presented to the DUT.
    task automatic model_update();
        logic [31:0] nxt;
        logic        pop_ok;
        pop_ok = bus.ras_pop && (m_q.size() > 0) && !bus.stall;
        if (bus.exc_req)             nxt = 32'h80;
        else if (bus.redirect_valid) nxt = bus.redirect_pc;
        else if (pop_ok)             nxt = m_q[m_q.size()-1];
        else if (bus.jump_valid && !bus.stall) nxt = bus.jump_target;
        else if (bus.stall)          nxt = m_pc;
        else                         nxt = m_pc + 32'd4;
        if (bus.exc_req) begin
            m_q.delete();
        end else if (!bus.redirect_valid && !bus.stall) begin
            if (bus.ras_push && bus.ras_pop && m_q.size() > 0) begin
                m_q[m_q.size()-1] = bus.ras_push_addr;
            end else if (bus.ras_push) begin
                m_q.push_back(bus.ras_push_addr);
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
            end else if (bus.ras_pop && m_q.size() > 0) begin
                void'(m_q.pop_back());
            end
        end
        m_pc = nxt;
    endtask

    function automatic logic [31:0] m_top();
        return (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'h0;
    endfunction

    task automatic step(input logic st, input logic ex, input logic rv, input logic [31:0] rp,
                        input logic jv, input logic [31:0] jt, input logic pu,
                        input logic [31:0] pa, input logic po);
        bus.stall          = st;
        bus.exc_req        = ex;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.jump_valid     = jv;
        bus.jump_target    = jt;
        bus.ras_push       = pu;
        bus.ras_push_addr  = pa;
        bus.ras_pop        = po;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.stall = 0; bus.exc_req = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.jump_valid = 0; bus.jump_target = 0; bus.ras_push = 0; bus.ras_push_addr = 0; bus.ras_pop = 0;
        m_pc = 32'h0;
        m_q.delete();
        @(posedge clk);
        #1;
        total++; if (bus.pc_o !== 32'h0) $display("FAIL rst_pc: got %h expected %h", bus.pc_o, 32'h0); else passed++;
        total++; if (bus.pc_plus_o !== 32'h4) $display("FAIL rst_pc_plus: got %h expected %h", bus.pc_plus_o, 32'h4); else passed++;
        total++; if (bus.ras_count_o !== 3'd0) $display("FAIL rst_count: got %0d expected 0", bus.ras_count_o); else passed++;
        total++; if (bus.ras_empty_o !== 1'b1) $display("FAIL rst_empty: got %b expected 1", bus.ras_empty_o); else passed++;
        total++; if (bus.ras_top_o !== 32'h0) $display("FAIL rst_top: got %h expected 0", bus.ras_top_o); else passed++;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            idle();
            exp_pc = 32'(i * 4);
            total++; if (bus.pc_o !== exp_pc) $display("FAIL free_run_%0d: got %h expected %h", i, bus.pc_o, exp_pc); else passed++;
        end
        // Asynchronous reset away from the clock edge.
        #3;
        reset = 1'b0;
        #1;
        m_pc = 32'h0;
        m_q.delete();
        total++; if (bus.pc_o !== 32'h0) $display("FAIL mid_reset_pc: got %h expected 0", bus.pc_o); else passed++;
        #2;
        reset = 1'b1;
        idle();
        total++; if (bus.pc_o !== 32'h4) $display("FAIL post_reset_pc: got %h expected 4", bus.pc_o); else passed++;
    endtask

    task automatic test_stall_redirect();
        step(0, 0, 1, 32'h10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 1, 32'h999, 0, 0, 0);
            total++; if (bus.pc_o !== 32'h10) $display("FAIL stall_hold_%0d: got %h expected 10", i, bus.pc_o); else passed++;
        end
        step(1, 0, 1, 32'h200, 0, 0, 0, 0, 0);
        total++; if (bus.pc_o !== 32'h200) $display("FAIL stall_redirect: got %h expected 200", bus.pc_o); else passed++;
    endtask

    task automatic test_priority();
        step(0, 0, 0, 0, 0, 0, 1, 32'h44, 0);
        total++; if (bus.ras_count_o !== 3'd1) $display("FAIL prio_pre_count: got %0d expected 1", bus.ras_count_o); else passed++;
        step(0, 1, 1, 32'h300, 1, 32'h400, 0, 0, 0);
        total++; if (bus.pc_o !== 32'h80) $display("FAIL prio_exc_pc: got %h expected 80", bus.pc_o); else passed++;
        total++; if (bus.ras_count_o !== 3'd0) $display("FAIL prio_exc_count: got %0d expected 0", bus.ras_count_o); else passed++;
        step(0, 0, 1, 32'h300, 1, 32'h400, 0, 0, 0);
        total++; if (bus.pc_o !== 32'h300) $display("FAIL prio_redirect: got %h expected 300", bus.pc_o); else passed++;
    endtask

    task automatic test_ras_call_return();
        step(0, 0, 0, 0, 1, 32'h100, 1, 32'h14, 0);
        total++; if (bus.pc_o !== 32'h100) $display("FAIL call_pc: got %h expected 100", bus.pc_o); else passed++;
        total++; if (bus.ras_count_o !== 3'd1) $display("FAIL call_count: got %0d expected 1", bus.ras_count_o); else passed++;
        total++; if (bus.ras_top_o !== 32'h14) $display("FAIL call_top: got %h expected 14", bus.ras_top_o); else passed++;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.pc_o !== 32'h14) $display("FAIL ret_pc: got %h expected 14", bus.pc_o); else passed++;
        total++; if (bus.ras_count_o !== 3'd0) $display("FAIL ret_count: got %0d expected 0", bus.ras_count_o); else passed++;
        total++; if (bus.ras_empty_o !== 1'b1) $display("FAIL ret_empty: got %b expected 1", bus.ras_empty_o); else passed++;
        // A stalled push must not reach the stack.
        step(1, 0, 0, 0, 0, 0, 1, 32'h55, 0);
        total++; if (bus.ras_count_o !== 3'd0) $display("FAIL stall_push_count: got %0d expected 0", bus.ras_count_o); else passed++;
        total++; if (bus.pc_o !== 32'h14) $display("FAIL stall_push_pc: got %h expected 14", bus.pc_o); else passed++;
    endtask

    task automatic test_ras_overflow();
        logic [31:0] addr [5];
        for (int i = 0; i < 5; i++) addr[i] = 32'h1000 + 32'(i) * 32'h100;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, addr[i], 0);
        total++; if (bus.ras_count_o !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", bus.ras_count_o); else passed++;
        total++; if (bus.ras_top_o !== addr[4]) $display("FAIL ovf_top: got %h expected %h", bus.ras_top_o, addr[4]); else passed++;
        for (int i = 4; i >= 1; i--) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1);
            total++; if (bus.pc_o !== addr[i]) $display("FAIL ovf_pop_%0d: got %h expected %h", i, bus.pc_o, addr[i]); else passed++;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.pc_o !== addr[1] + 32'd4) $display("FAIL empty_pop_pc: got %h expected %h", bus.pc_o, addr[1] + 32'd4); else passed++;
        total++; if (bus.ras_count_o !== 3'd0) $display("FAIL empty_pop_count: got %0d expected 0", bus.ras_count_o); else passed++;
    endtask

    task automatic test_wrap_push_pop();
        step(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0);
        idle();
        total++; if (bus.pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pre: got %h expected fffffffc", bus.pc_o); else passed++;
        total++; if (bus.pc_plus_o !== 32'h0) $display("FAIL wrap_plus: got %h expected 0", bus.pc_plus_o); else passed++;
        idle();
        total++; if (bus.pc_o !== 32'h0) $display("FAIL wrap_pc: got %h expected 0", bus.pc_o); else passed++;
        step(0, 0, 0, 0, 0, 0, 1, 32'h20, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h40, 1);
        total++; if (bus.pc_o !== 32'h20) $display("FAIL pushpop_pc: got %h expected 20", bus.pc_o); else passed++;
        total++; if (bus.ras_top_o !== 32'h40) $display("FAIL pushpop_top: got %h expected 40", bus.ras_top_o); else passed++;
        total++; if (bus.ras_count_o !== 3'd1) $display("FAIL pushpop_count: got %0d expected 1", bus.ras_count_o); else passed++;
    endtask

    task automatic test_random();
        logic st, ex, rv, jv, pu, po;
        logic [31:0] rp, jt, pa;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 3) == 0);
            ex = ($urandom_range(0, 31) == 0);
            rv = ($urandom_range(0, 15) == 0);
            jv = ($urandom_range(0, 7) == 0);
            pu = ($urandom_range(0, 2) == 0);
            po = ($urandom_range(0, 2) == 0);
            rp = $urandom & 32'hFFFF_FFFC;
            jt = $urandom & 32'hFFFF_FFFC;
            pa = $urandom & 32'hFFFF_FFFC;
            step(st, ex, rv, rp, jv, jt, pu, pa, po);
            total++; if (bus.pc_o !== m_pc) $display("FAIL rand_pc@%0d: got %h expected %h", i, bus.pc_o, m_pc); else passed++;
            total++; if (bus.ras_top_o !== m_top()) $display("FAIL rand_top@%0d: got %h expected %h", i, bus.ras_top_o, m_top()); else passed++;
            total++; if (bus.ras_count_o !== 3'(m_q.size())) $display("FAIL rand_count@%0d: got %0d expected %0d", i, bus.ras_count_o, m_q.size()); else passed++;
            total++; if (bus.ras_empty_o !== (m_q.size() == 0)) $display("FAIL rand_empty@%0d: got %b expected %b", i, bus.ras_empty_o, (m_q.size() == 0)); else passed++;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_free_run();
        test_stall_redirect();
        test_priority();
        test_ras_call_return();
        test_ras_overflow();
        test_wrap_push_pop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
